// File: rtl/load_store_unit.sv
// Load/store initiator: doubleword-aligned memory port, read-modify-write for sub-word stores.
// Optional range check on the request address is compiled in with `LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        memoryread,
    output logic        memorywrite,
    output logic [63:0] address,
    output logic [63:0] write_data,
    input  logic [63:0] read_data
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

    state_t      state_q;
    logic [2:0]  off_q;
    logic [2:0]  funct3_q;
    logic [63:0] wdata_q;
    logic        memoryread_q;
    logic        memorywrite_q;
    logic [63:0] address_q;
    logic [63:0] write_data_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [63:0] resp_rdata_q;

    logic        acc_err_d;
    logic        misalign_d;
    logic        illegal_d;
    logic        oor_d;
    logic [63:0] acc_addr_d;
    logic [5:0]  shamt_d;
    logic [63:0] size_mask_d;
    logic [63:0] lane_mask_d;
    logic [63:0] merged_d;
    logic [63:0] shifted_d;
    logic [63:0] ld_ext_d;

    // Request checks and the aligned port address, evaluated on the live request.
    always_comb begin
        misalign_d = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_d = req_addr[0];
            2'b10:   misalign_d = |req_addr[1:0];
            2'b11:   misalign_d = |req_addr[2:0];
            default: misalign_d = 1'b0;
        endcase
        illegal_d = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef LSU_BOUNDS_CHECK_EN
        oor_d      = (req_addr >= 64'(MEM_BYTES));
        acc_addr_d = {req_addr[63:3], 3'b000};
`else
        oor_d      = 1'b0;
        acc_addr_d = (req_addr % 64'(MEM_BYTES)) & ~64'h7;
`endif
        acc_err_d = misalign_d | illegal_d | oor_d;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        shamt_d = {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   size_mask_d = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask_d = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask_d = 64'h0000_0000_FFFF_FFFF;
            default: size_mask_d = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane_mask_d = size_mask_d << shamt_d;
        merged_d    = (read_data & ~lane_mask_d) | ((wdata_q << shamt_d) & lane_mask_d);
        shifted_d   = read_data >> shamt_d;
        case (funct3_q)
            3'b000:  ld_ext_d = {{56{shifted_d[7]}},  shifted_d[7:0]};
            3'b001:  ld_ext_d = {{48{shifted_d[15]}}, shifted_d[15:0]};
            3'b010:  ld_ext_d = {{32{shifted_d[31]}}, shifted_d[31:0]};
            3'b100:  ld_ext_d = {56'd0, shifted_d[7:0]};
            3'b101:  ld_ext_d = {48'd0, shifted_d[15:0]};
            3'b110:  ld_ext_d = {32'd0, shifted_d[31:0]};
            default: ld_ext_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            off_q         <= 3'd0;
            funct3_q      <= 3'd0;
            wdata_q       <= 64'd0;
            memoryread_q  <= 1'b0;
            memorywrite_q <= 1'b0;
            address_q     <= 64'd0;
            write_data_q  <= 64'd0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= 64'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        off_q        <= req_addr[2:0];
                        funct3_q     <= req_funct3;
                        wdata_q      <= req_wdata;
                        resp_rdata_q <= 64'd0;
                        resp_error_q <= 1'b0;
                        if (acc_err_d) begin
                            resp_error_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!req_write) begin
                            memoryread_q <= 1'b1;
                            address_q    <= acc_addr_d;
                            state_q      <= S_LOAD;
                        end else if (req_funct3[1:0] == 2'b11) begin
                            memorywrite_q <= 1'b1;
                            write_data_q  <= req_wdata;
                            address_q     <= acc_addr_d;
                            state_q       <= S_WRITE;
                        end else begin
                            memoryread_q <= 1'b1;
                            address_q    <= acc_addr_d;
                            state_q      <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    memoryread_q <= 1'b0;
                    resp_rdata_q <= ld_ext_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    memoryread_q  <= 1'b0;
                    memorywrite_q <= 1'b1;
                    write_data_q  <= merged_d;
                    state_q       <= S_WRITE;
                end
                S_WRITE: begin
                    memorywrite_q <= 1'b0;
                    resp_valid_q  <= 1'b1;
                    state_q       <= S_RESP;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_error  = resp_error_q;
    assign memoryread  = memoryread_q;
    assign memorywrite = memorywrite_q;
    assign address     = address_q;
    assign write_data  = write_data_q;

endmodule
